// File: rtl/iteration_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// iteration_ctrl_pkg
// Shared definitions for the Mandelbrot pixel iteration controller.
//   iter_state_t      : controller FSM states (IDLE, ITERATE, DONE)
//   FRAC_BITS         : fractional bits of the signed Q3.13 number format
//   ESCAPE_THRESHOLD  : 4.0 expressed in the squared-product domain
//                       (a Q3.13 value squared carries 2*FRAC_BITS fraction
//                       bits, so 4.0 becomes 4 << 26 = 2^28)
// ----------------------------------------------------------------------------
package iteration_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ITERATE = 2'd1,
        DONE    = 2'd2
    } iter_state_t;

    localparam int FRAC_BITS = 13;

    localparam int unsigned ESCAPE_THRESHOLD = 32'd4 << (2 * FRAC_BITS);

endpackage

// File: rtl/iteration_ctrl_escape_check.sv
// ----------------------------------------------------------------------------
// escape_check
// Combinational escape test for the current orbit point: flags when
// |z|^2 = zr*zr + zi*zi is at least 4.0. The magnitude is formed exactly in
// 2*WIDTH+1 unsigned bits, so no intermediate overflow is possible.
//   z_real, z_imaginary : current orbit point (signed Q3.13)
//   is_escaped          : 1 when |z|^2 >= 4.0
// ----------------------------------------------------------------------------
import iteration_ctrl_pkg::*;

module escape_check #(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] z_real,
    input  logic signed [WIDTH-1:0] z_imaginary,
    output logic                    is_escaped
);

    logic signed [2*WIDTH-1:0] zrExt;
    logic signed [2*WIDTH-1:0] ziExt;
    logic signed [2*WIDTH-1:0] sqReal;
    logic signed [2*WIDTH-1:0] sqImag;
    logic        [2*WIDTH:0]   magSq;

    // Squares are never negative, so zero-extending them into the sum is
    // safe; even (-2^15)^2 twice fits comfortably in the 33-bit result.
    always_comb begin
        zrExt      = (2*WIDTH)'(z_real);
        ziExt      = (2*WIDTH)'(z_imaginary);
        sqReal     = zrExt * zrExt;
        sqImag     = ziExt * ziExt;
        magSq      = {1'b0, sqReal} + {1'b0, sqImag};
        is_escaped = (magSq >= (2*WIDTH+1)'(ESCAPE_THRESHOLD));
    end

endmodule

// File: rtl/new_z.sv
// ----------------------------------------------------------------------------
// new_z
// Combinational complex datapath computing z' = z^2 + c in signed fixed point.
// Results wrap at WIDTH bits; there is no saturation.
//   z_real, z_imaginary     : current orbit point (signed, FRAC fraction bits)
//   c_real, c_imaginary     : pixel constant (signed, FRAC fraction bits)
//   new_real, new_imaginary : next orbit point (signed, wrapped to WIDTH)
// ----------------------------------------------------------------------------
module new_z #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 13
) (
    input  logic signed [WIDTH-1:0] z_real,
    input  logic signed [WIDTH-1:0] z_imaginary,
    input  logic signed [WIDTH-1:0] c_real,
    input  logic signed [WIDTH-1:0] c_imaginary,
    output logic signed [WIDTH-1:0] new_real,
    output logic signed [WIDTH-1:0] new_imaginary
);

    logic signed [2*WIDTH-1:0] zrExt;
    logic signed [2*WIDTH-1:0] ziExt;
    logic signed [2*WIDTH-1:0] prodRR;
    logic signed [2*WIDTH-1:0] prodII;
    logic signed [2*WIDTH-1:0] prodRI;
    logic signed [2*WIDTH:0]   diff;

    // Operands are sign-extended to full product width before multiplying so
    // every product is exact. The real part needs one extra bit because
    // zr^2 - zi^2 can span the full range of both squares.
    always_comb begin
        zrExt  = (2*WIDTH)'(z_real);
        ziExt  = (2*WIDTH)'(z_imaginary);
        prodRR = zrExt * zrExt;
        prodII = ziExt * ziExt;
        prodRI = zrExt * ziExt;
        diff   = {prodRR[2*WIDTH-1], prodRR} - {prodII[2*WIDTH-1], prodII};
    end

    // Rescaling back to the Q format is an arithmetic shift by FRAC; the
    // factor of two in 2*zr*zi is folded in by shifting one place less.
    // Truncating to WIDTH bits before adding c gives the intended wrap.
    always_comb begin
        new_real      = WIDTH'(diff >>> FRAC) + c_real;
        new_imaginary = WIDTH'(prodRI >>> (FRAC - 1)) + c_imaginary;
    end

endmodule

// File: rtl/iteration_ctrl.sv
// ----------------------------------------------------------------------------
// iteration_ctrl
// Per-pixel Mandelbrot iteration controller. On an accepted start it latches
// c, starts the orbit at z = 0 and iterates z <- z^2 + c until |z|^2 >= 4.0
// or the iteration cap is reached, then pulses done for one cycle.
//   clk          : clock, all state changes on the rising edge
//   rst          : synchronous active-high reset
//   start        : request a new pixel evaluation (accepted only in IDLE)
//   c_real/_imag : pixel constant, sampled with the accepted start
//   busy         : high while iterating
//   done         : one-cycle completion pulse
//   iter_count   : iterations reached at completion (held until next start)
//   escaped      : 1 = orbit escaped, 0 = hit MAX_ITER (held likewise)
//   abort        : only with ITERATION_CTRL_ABORT_EN defined; drops the
//                  current pixel and returns to IDLE without a done pulse
// Build option: define ITERATION_CTRL_ABORT_EN to add the abort input.
// ----------------------------------------------------------------------------
import iteration_ctrl_pkg::*;

module iteration_ctrl #(
    parameter int FIXED_POINT_WIDTH = 16,
    parameter int ITER_WIDTH        = 8,
    parameter int MAX_ITER          = 255
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
`ifdef ITERATION_CTRL_ABORT_EN
    input  logic                                abort,
`endif
    input  logic signed [FIXED_POINT_WIDTH-1:0] c_real,
    input  logic signed [FIXED_POINT_WIDTH-1:0] c_imaginary,
    output logic                                busy,
    output logic                                done,
    output logic        [ITER_WIDTH-1:0]        iter_count,
    output logic                                escaped
);

    localparam logic [ITER_WIDTH-1:0] MAX_CNT = ITER_WIDTH'(MAX_ITER);

    iter_state_t state;
    iter_state_t stateNext;

    logic signed [FIXED_POINT_WIDTH-1:0] cReal;
    logic signed [FIXED_POINT_WIDTH-1:0] cImag;
    logic signed [FIXED_POINT_WIDTH-1:0] zReal;
    logic signed [FIXED_POINT_WIDTH-1:0] zImag;
    logic signed [FIXED_POINT_WIDTH-1:0] cRealNext;
    logic signed [FIXED_POINT_WIDTH-1:0] cImagNext;
    logic signed [FIXED_POINT_WIDTH-1:0] zRealNext;
    logic signed [FIXED_POINT_WIDTH-1:0] zImagNext;
    logic signed [FIXED_POINT_WIDTH-1:0] newReal;
    logic signed [FIXED_POINT_WIDTH-1:0] newImag;
    logic        [ITER_WIDTH-1:0]        cnt;
    logic        [ITER_WIDTH-1:0]        cntNext;
    logic        [ITER_WIDTH-1:0]        iterCountNext;
    logic                                escapedNext;
    logic                                isEscaped;

    new_z #(
        .WIDTH (FIXED_POINT_WIDTH),
        .FRAC  (FRAC_BITS)
    ) uNewZ (
        .z_real        (zReal),
        .z_imaginary   (zImag),
        .c_real        (cReal),
        .c_imaginary   (cImag),
        .new_real      (newReal),
        .new_imaginary (newImag)
    );

    escape_check #(
        .WIDTH (FIXED_POINT_WIDTH)
    ) uEscapeCheck (
        .z_real      (zReal),
        .z_imaginary (zImag),
        .is_escaped  (isEscaped)
    );

    // State and datapath registers. Reset wins over everything and wipes the
    // pixel in flight, so an interrupted evaluation never produces a done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cReal      <= '0;
            cImag      <= '0;
            zReal      <= '0;
            zImag      <= '0;
            cnt        <= '0;
            iter_count <= '0;
            escaped    <= '0;
        end else begin
            state      <= stateNext;
            cReal      <= cRealNext;
            cImag      <= cImagNext;
            zReal      <= zRealNext;
            zImag      <= zImagNext;
            cnt        <= cntNext;
            iter_count <= iterCountNext;
            escaped    <= escapedNext;
        end
    end

    // Next-state and output logic. Each ITERATE cycle judges the current z
    // before stepping it, and the escape test outranks the iteration cap so a
    // point that escapes exactly on the last allowed step reports escaped=1.
    // start is only looked at in IDLE, so requests during a run are dropped.
    always_comb begin
        stateNext     = state;
        cRealNext     = cReal;
        cImagNext     = cImag;
        zRealNext     = zReal;
        zImagNext     = zImag;
        cntNext       = cnt;
        iterCountNext = iter_count;
        escapedNext   = escaped;
        busy          = 1'b0;
        done          = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    cRealNext     = c_real;
                    cImagNext     = c_imaginary;
                    zRealNext     = '0;
                    zImagNext     = '0;
                    cntNext       = '0;
                    iterCountNext = '0;
                    escapedNext   = 1'b0;
                    stateNext     = ITERATE;
                end
            end

            ITERATE: begin
                busy = 1'b1;
`ifdef ITERATION_CTRL_ABORT_EN
                if (abort) begin
                    iterCountNext = '0;
                    escapedNext   = 1'b0;
                    stateNext     = IDLE;
                end else
`endif
                if (isEscaped) begin
                    iterCountNext = cnt;
                    escapedNext   = 1'b1;
                    stateNext     = DONE;
                end else if (cnt == MAX_CNT) begin
                    iterCountNext = MAX_CNT;
                    escapedNext   = 1'b0;
                    stateNext     = DONE;
                end else begin
                    zRealNext = newReal;
                    zImagNext = newImag;
                    cntNext   = cnt + 1'b1;
                end
            end

            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iteration_ctrl.sv
// ----------------------------------------------------------------------------
// tb_iteration_ctrl
// Self-checking bench for iteration_ctrl in its default build (no abort).
// Directed pixels use known Mandelbrot results; random pixels are compared
// against a plain-arithmetic orbit model. Also covers reset mid-run and start
// held high across a whole evaluation.
// ----------------------------------------------------------------------------
module tb_iteration_ctrl;

    localparam int FPW   = 16;
    localparam int IW    = 8;
    localparam int MAXI  = 255;
    localparam int LIMIT = 2000;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [FPW-1:0]  c_real;
    logic [FPW-1:0]  c_imaginary;
    logic            busy;
    logic            done;
    logic [IW-1:0]   iter_count;
    logic            escaped;

    int checks = 0;
    int errors = 0;

    iteration_ctrl #(
        .FIXED_POINT_WIDTH (FPW),
        .ITER_WIDTH        (IW),
        .MAX_ITER          (MAXI)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .c_real      (c_real),
        .c_imaginary (c_imaginary),
        .busy        (busy),
        .done        (done),
        .iter_count  (iter_count),
        .escaped     (escaped)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Wraps an integer to a signed 16-bit value.
    function automatic longint wrap16(input longint v);
        shortint s;
        s = shortint'(v);
        return longint'(s);
    endfunction

    // Reference orbit: integer complex arithmetic in Q3.13, floor rescale,
    // 16-bit wrap. Returns the iteration count and whether it escaped.
    function automatic void refModel(input logic signed [15:0] cr,
                                     input logic signed [15:0] ci,
                                     output int n, output bit esc);
        longint zr, zi, nr, ni;
        zr  = 0;
        zi  = 0;
        n   = 0;
        esc = 1'b0;
        for (int k = 0; k <= MAXI; k++) begin
            n = k;
            if (zr * zr + zi * zi >= 64'sd268435456) begin
                esc = 1'b1;
                return;
            end
            if (k == MAXI) return;
            nr = wrap16(((zr * zr - zi * zi) >>> 13) + longint'(cr));
            ni = wrap16(((2 * zr * zi) >>> 13) + longint'(ci));
            zr = nr;
            zi = ni;
        end
    endfunction

    // Single comparison point: counts the check and reports any failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Presents a pixel at a falling edge and returns at the falling edge
    // right after the accepting rising edge. start stays high if hold is set.
    task automatic applyStimulus(input logic [15:0] cr, input logic [15:0] ci,
                                 input bit hold);
        @(negedge clk);
        start       = 1'b1;
        c_real      = cr;
        c_imaginary = ci;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Called at the falling edge right after acceptance; counts that edge as
    // 1 and returns at the falling edge where done is seen. A pixel with final
    // count N shows done N+1 rising edges after acceptance, i.e. cycles=N+2.
    task automatic waitForDone(output int cycles);
        cycles = 1;
        while (!done && cycles < LIMIT) begin
            @(negedge clk);
            cycles++;
        end
        if (!done) checkOutput("done_timeout", 32'(done), 32'd1);
    endtask

    // Full evaluation of one pixel with completion and hold-value checks.
    task automatic runPixel(input string tag, input logic [15:0] cr,
                            input logic [15:0] ci, input int expN,
                            input bit expEsc, input bit hold);
        int cycles;
        applyStimulus(cr, ci, hold);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_clear"}, 32'(iter_count), 32'd0);
        waitForDone(cycles);
        checkOutput({tag, "_latency"}, 32'(cycles), 32'(expN + 2));
        checkOutput({tag, "_iter"}, 32'(iter_count), 32'(expN));
        checkOutput({tag, "_esc"}, 32'(escaped), 32'(expEsc));
        checkOutput({tag, "_busylow"}, 32'(busy), 32'd0);
        if (!hold) begin
            @(negedge clk);
            checkOutput({tag, "_pulse"}, 32'(done), 32'd0);
            checkOutput({tag, "_hold"}, 32'(iter_count), 32'(expN));
            checkOutput({tag, "_holdesc"}, 32'(escaped), 32'(expEsc));
        end
    endtask

    initial begin
        int n;
        bit e;
        int cycles;
        int doneSeen;
        logic [15:0] rcr;
        logic [15:0] rci;

        rst         = 1'b1;
        start       = 1'b0;
        c_real      = '0;
        c_imaginary = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_iter", 32'(iter_count), 32'd0);
        checkOutput("rst_esc", 32'(escaped), 32'd0);
        rst = 1'b0;

        // Directed pixels with known outcomes
        runPixel("c_zero", 16'h0000, 16'h0000, 255, 1'b0, 1'b0);
        runPixel("c_one", 16'h2000, 16'h0000, 2, 1'b1, 1'b0);
        runPixel("c_m2", 16'hC000, 16'h0000, 1, 1'b1, 1'b0);
        runPixel("c_quarter", 16'h0800, 16'h0000, 255, 1'b0, 1'b0);

        // Random pixels with |c| < 2.0 against the orbit model
        for (int i = 0; i < 16; i++) begin
            rcr = 16'($signed($urandom_range(0, 32766)) - 16383);
            rci = 16'($signed($urandom_range(0, 32766)) - 16383);
            refModel(rcr, rci, n, e);
            runPixel($sformatf("rand%0d", i), rcr, rci, n, e, 1'b0);
        end

        // Reset in the middle of an evaluation aborts it silently
        applyStimulus(16'h0000, 16'h0000, 1'b0);
        repeat (9) @(negedge clk);
        checkOutput("midrun_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_iter", 32'(iter_count), 32'd0);
        checkOutput("abort_esc", 32'(escaped), 32'd0);
        doneSeen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("abort_nodone", 32'(doneSeen), 32'd0);
        runPixel("after_rst", 16'h2000, 16'h0000, 2, 1'b1, 1'b0);

        // start held high: one evaluation per IDLE acceptance
        runPixel("held", 16'h2000, 16'h0000, 2, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("held_pulse", 32'(done), 32'd0);
        checkOutput("held_idle", 32'(busy), 32'd0);
        checkOutput("held_keep", 32'(iter_count), 32'd2);
        @(negedge clk);
        checkOutput("held_reaccept", 32'(busy), 32'd1);
        checkOutput("held_clear", 32'(iter_count), 32'd0);
        start = 1'b0;
        waitForDone(cycles);
        checkOutput("held2_latency", 32'(cycles), 32'd4);
        checkOutput("held2_iter", 32'(iter_count), 32'd2);
        checkOutput("held2_esc", 32'(escaped), 32'd1);
        doneSeen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("held2_single", 32'(doneSeen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
